seven_seg_scan_counter: RTL and testbench

Parametrised multiplexed seven-segment driver with a built-in cascaded BCD up-counter. It replaces the fixed 4+1-digit counter/display block. It generalises digit count, tick period and scan rate, and adds the following:
- message (glyph) mode with per-digit codes
- leading-zero blanking
- synchronous clear and load
- overflow flag

It sits between board I/O (anodes/cathodes) and game logic, which supplies the score enable and message glyphs.

---
 rtl/seven_seg_scan_counter.sv | 157 +++++++++++++++
 tb/tb_seven_seg_scan_counter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_counter.sv
// Multiplexed seven-segment driver with a built-in cascaded BCD up-counter,
// message glyph mode, leading-zero blanking and an overflow pulse.
module seven_seg_scan_counter #(
    parameter int unsigned NUM_DIGITS = 5,
    parameter int unsigned TICK_DIV   = 100000000,
    parameter int unsigned DWELL      = 131072
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    count_en,
    input  logic                    clear,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_bcd,
    input  logic                    mode,
    input  logic [4*NUM_DIGITS-1:0] msg,
    input  logic                    blank_lz,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic [6:0]              seg,
    output logic                    tick,
    output logic                    overflow,
    output logic [4*NUM_DIGITS-1:0] bcd_value
);

    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam int unsigned DW = $clog2(DWELL);
    localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    logic [PW-1:0]           presc_q, presc_d;
    logic                    tick_q, tick_d;
    logic                    ovf_q, ovf_d;
    logic [4*NUM_DIGITS-1:0] cnt_q, cnt_d;
    logic [DW-1:0]           dwell_q, dwell_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [NUM_DIGITS-1:0]   anode_q, anode_d;
    logic [6:0]              seg_q, seg_d;

    logic                    presc_end;
    logic [4*NUM_DIGITS-1:0] inc_val, ld_sat;
    logic                    carry;
    logic [NUM_DIGITS-1:0]   blank;
    logic                    zero_above;
    logic [3:0]              code;

    // Counter path: increment, tick and overflow are all registered on the
    // terminal-count edge so they appear together in the same cycle.
    always_comb begin
        presc_end = (presc_q == PRESC_LAST);
        carry     = 1'b1;
        inc_val   = cnt_q;
        ld_sat    = load_bcd;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (carry) begin
                if (cnt_q[4*i +: 4] == 4'd9) begin
                    inc_val[4*i +: 4] = 4'd0;
                end else begin
                    inc_val[4*i +: 4] = cnt_q[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
            if (load_bcd[4*i +: 4] > 4'd9) ld_sat[4*i +: 4] = 4'd9;
        end

        presc_d = presc_end ? '0 : presc_q + 1'b1;
        tick_d  = presc_end;
        ovf_d   = 1'b0;
        cnt_d   = cnt_q;
        if (clear) begin
            presc_d = '0;
            tick_d  = 1'b0;
            cnt_d   = '0;
        end else if (load) begin
            cnt_d = ld_sat;
        end else if (presc_end && count_en) begin
            cnt_d = inc_val;
            ovf_d = carry;
        end
    end

    always_comb begin
        dwell_d = (dwell_q == DWELL_LAST) ? '0 : dwell_q + 1'b1;
        idx_d   = idx_q;
        if (dwell_q == DWELL_LAST) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end

    // Walk from the most significant digit down; digit 0 is never blanked.
    always_comb begin
        zero_above = 1'b1;
        blank      = '0;
        for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
            if (cnt_q[4*(NUM_DIGITS-1-j) +: 4] != 4'd0) zero_above = 1'b0;
            if ((j != NUM_DIGITS - 1) && zero_above) blank[NUM_DIGITS-1-j] = 1'b1;
        end
    end

    always_comb begin
        code    = 4'hF;
        anode_d = '1;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                anode_d[i] = 1'b0;
                if (mode)                     code = msg[4*i +: 4];
                else if (blank_lz && blank[i]) code = 4'hF;
                else                          code = cnt_q[4*i +: 4];
            end
        end
        case (code)
            4'h0: seg_d = 7'b0000001;
            4'h1: seg_d = 7'b1001111;
            4'h2: seg_d = 7'b0010010;
            4'h3: seg_d = 7'b0000110;
            4'h4: seg_d = 7'b1001100;
            4'h5: seg_d = 7'b0100100;
            4'h6: seg_d = 7'b0100000;
            4'h7: seg_d = 7'b0001111;
            4'h8: seg_d = 7'b0000000;
            4'h9: seg_d = 7'b0000100;
            4'hA: seg_d = 7'b1110001;
            4'hB: seg_d = 7'b1001111;
            4'hC: seg_d = 7'b1000001;
            4'hD: seg_d = 7'b0110000;
            4'hE: seg_d = 7'b1111110;
            default: seg_d = 7'b1111111;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            dwell_q <= '0;
            idx_q   <= '0;
            anode_q <= '1;
            seg_q   <= '1;
        end else begin
            presc_q <= presc_d;
            tick_q  <= tick_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
            dwell_q <= dwell_d;
            idx_q   <= idx_d;
            anode_q <= anode_d;
            seg_q   <= seg_d;
        end
    end

    assign anode     = anode_q;
    assign seg       = seg_q;
    assign tick      = tick_q;
    assign overflow  = ovf_q;
    assign bcd_value = cnt_q;

endmodule

// File: tb/tb_seven_seg_scan_counter.sv
// Directed self-checking bench for seven_seg_scan_counter (5 digits, TICK_DIV=4, DWELL=3).
module tb_seven_seg_scan_counter;

    logic        clk = 1'b0;
    logic        reset, count_en, clear, load, mode, blank_lz;
    logic [19:0] load_bcd, msg, bcd_value;
    logic [4:0]  anode;
    logic [6:0]  seg;
    logic        tick, overflow;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    seven_seg_scan_counter #(
        .NUM_DIGITS(5),
        .TICK_DIV(4),
        .DWELL(3)
    ) dut (
        .clk(clk), .reset(reset), .count_en(count_en), .clear(clear), .load(load),
        .load_bcd(load_bcd), .mode(mode), .msg(msg), .blank_lz(blank_lz),
        .anode(anode), .seg(seg), .tick(tick), .overflow(overflow), .bcd_value(bcd_value)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        count_en = 1'b1;
        repeat (8) step();
        compared++;
        if (bcd_value !== 20'h00002) begin
            mismatched++;
            $display("FAIL prerun_bcd got %h want %h", bcd_value, 20'h00002);
        end
        count_en = 1'b0;
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        compared++;
        if (anode !== 5'b11111 || seg !== 7'h7F || bcd_value !== 20'h0 || tick !== 1'b0) begin
            mismatched++;
            $display("FAIL async_reset got an=%b seg=%h bcd=%h tick=%b want 11111/7f/00000/0",
                     anode, seg, bcd_value, tick);
        end
        step();
        step();
        reset = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            compared++;
            if (tick !== ((k % 4) == 0)) begin
                mismatched++;
                $display("FAIL tick_period cycle %0d got %b want %b", k, tick, (k % 4) == 0);
            end
        end
    endtask

    task automatic test_count();
        clear = 1'b1;
        count_en = 1'b1;
        step();
        clear = 1'b0;
        repeat (48) step();
        compared++;
        if (bcd_value !== 20'h00012) begin
            mismatched++;
            $display("FAIL count12 got %h want %h", bcd_value, 20'h00012);
        end
        count_en = 1'b0;
    endtask

    task automatic test_scan();
        logic [4:0] prev, expa;
        bit found;
        found = 1'b0;
        prev = anode;
        for (int n = 0; n < 20 && !found; n++) begin
            step();
            if (anode == 5'b11110 && prev != 5'b11110) found = 1'b1;
            prev = anode;
        end
        compared++;
        if (!found) begin
            mismatched++;
            $display("FAIL scan_start got anode=%b want 11110 within 20 cycles", anode);
        end else begin
            for (int k = 0; k < 15; k++) begin
                expa = ~(5'b00001 << (k / 3));
                compared++;
                if (anode !== expa) begin
                    mismatched++;
                    $display("FAIL scan_seq step %0d got %b want %b", k, anode, expa);
                end
                step();
            end
        end
    endtask

    task automatic test_overflow();
        int ovf_count;
        clear = 1'b1;
        count_en = 1'b1;
        step();
        clear = 1'b0;
        load = 1'b1;
        load_bcd = 20'h99998;
        step();
        load = 1'b0;
        ovf_count = 0;
        for (int s = 1; s <= 8; s++) begin
            step();
            if (overflow) begin
                ovf_count++;
                compared++;
                if (tick !== 1'b1 || bcd_value !== 20'h0) begin
                    mismatched++;
                    $display("FAIL ovf_coincide got tick=%b bcd=%h want 1/00000", tick, bcd_value);
                end
            end
            if (s == 3) begin
                compared++;
                if (bcd_value !== 20'h99999) begin
                    mismatched++;
                    $display("FAIL pre_wrap got %h want %h", bcd_value, 20'h99999);
                end
            end
        end
        compared++;
        if (ovf_count !== 1 || bcd_value !== 20'h0) begin
            mismatched++;
            $display("FAIL overflow_once got pulses=%0d bcd=%h want 1/00000", ovf_count, bcd_value);
        end
        count_en = 1'b0;
    endtask

    task automatic test_clear_load();
        bit found;
        found = 1'b0;
        count_en = 1'b1;
        for (int n = 0; n < 10 && !found; n++) begin
            step();
            if (tick) found = 1'b1;
        end
        compared++;
        if (!found) begin
            mismatched++;
            $display("FAIL tick_wait got no tick want tick within 10 cycles");
        end
        repeat (3) step();
        clear = 1'b1;
        load = 1'b1;
        load_bcd = 20'h12345;
        step();
        clear = 1'b0;
        load = 1'b0;
        compared++;
        if (bcd_value !== 20'h0 || tick !== 1'b0 || overflow !== 1'b0) begin
            mismatched++;
            $display("FAIL clear_prio got bcd=%h tick=%b ovf=%b want 00000/0/0", bcd_value, tick, overflow);
        end
        for (int k = 1; k <= 4; k++) begin
            step();
            compared++;
            if (tick !== (k == 4)) begin
                mismatched++;
                $display("FAIL presc_restart cycle %0d got %b want %b", k, tick, k == 4);
            end
        end
        compared++;
        if (bcd_value !== 20'h00001) begin
            mismatched++;
            $display("FAIL count_after_clear got %h want %h", bcd_value, 20'h00001);
        end
        repeat (3) step();
        load = 1'b1;
        load_bcd = 20'h1F3A2;
        step();
        load = 1'b0;
        count_en = 1'b0;
        compared++;
        if (bcd_value !== 20'h19392 || tick !== 1'b1) begin
            mismatched++;
            $display("FAIL load_sat got bcd=%h tick=%b want 19392/1", bcd_value, tick);
        end
    endtask

    task automatic test_message();
        logic [34:0] expv;
        logic [4:0]  expa;
        int d;
        expv = {7'h7F, 7'h71, 7'h4F, 7'h41, 7'h30};
        mode = 1'b1;
        msg = 20'hFABCD;
        step();
        for (int n = 0; n < 15; n++) begin
            d = -1;
            for (int i = 0; i < 5; i++) if (anode[i] == 1'b0) d = i;
            compared++;
            if (d < 0) begin
                mismatched++;
                $display("FAIL msg_anode got %b want one low bit", anode);
            end else begin
                expa = ~(5'b00001 << d);
                if (anode !== expa || seg !== expv[d*7 +: 7]) begin
                    mismatched++;
                    $display("FAIL msg_digit%0d got an=%b seg=%h want %b/%h", d, anode, seg, expa, expv[d*7 +: 7]);
                end
            end
            step();
        end
        mode = 1'b0;
    endtask

    task automatic test_blank_lz();
        logic [19:0] vals [4];
        logic        blz  [4];
        logic [34:0] exps [4];
        logic [34:0] expv;
        logic [4:0]  expa;
        int d;
        vals[0] = 20'h00040; blz[0] = 1'b1; exps[0] = {7'h7F, 7'h7F, 7'h7F, 7'h4C, 7'h01};
        vals[1] = 20'h00000; blz[1] = 1'b1; exps[1] = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h01};
        vals[2] = 20'h00040; blz[2] = 1'b0; exps[2] = {7'h01, 7'h01, 7'h01, 7'h4C, 7'h01};
        vals[3] = 20'h10203; blz[3] = 1'b1; exps[3] = {7'h4F, 7'h01, 7'h12, 7'h01, 7'h06};
        for (int c = 0; c < 4; c++) begin
            mode = 1'b0;
            load = 1'b1;
            load_bcd = vals[c];
            blank_lz = blz[c];
            step();
            load = 1'b0;
            step();
            expv = exps[c];
            for (int n = 0; n < 15; n++) begin
                d = -1;
                for (int i = 0; i < 5; i++) if (anode[i] == 1'b0) d = i;
                compared++;
                if (d < 0) begin
                    mismatched++;
                    $display("FAIL lz_anode case %0d got %b want one low bit", c, anode);
                end else begin
                    expa = ~(5'b00001 << d);
                    if (anode !== expa || seg !== expv[d*7 +: 7]) begin
                        mismatched++;
                        $display("FAIL lz case %0d digit%0d got an=%b seg=%h want %b/%h",
                                 c, d, anode, seg, expa, expv[d*7 +: 7]);
                    end
                end
                step();
            end
        end
        blank_lz = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        count_en = 1'b0;
        clear = 1'b0;
        load = 1'b0;
        load_bcd = '0;
        mode = 1'b0;
        msg = '0;
        blank_lz = 1'b0;
        step();
        step();
        reset = 1'b0;
        test_reset();
        test_count();
        test_scan();
        test_overflow();
        test_clear_load();
        test_message();
        test_blank_lz();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
